moore_seq_detector: RTL
=======================

// Module: moore_seq_detector
// PURPOSE
//  Parametrised Moore-type serial pattern detector. Generalises our fixed 5-state "1100" detector.
//  Pattern value, pattern length and overlap mode are parameters. Adds an input enable, a synchronous clear
//  and an optional saturating match counter.
//  Sits behind a synchronised serial input (button/bit stream); z drives an LED or downstream event logic.
// PARAMETERS
//  PAT_LEN  4        pattern length in bits, 2..16
//  PATTERN  4'b1100  pattern value [PAT_LEN-1:0]; MSB is the first bit received
//  OVERLAP  1        1: a match may reuse its trailing bits; 0: detection restarts after each match
//  CNT_W    8        match counter width (used only with MATCH_COUNT_EN)
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      asynchronous active-low reset
//  en         in   1      1: consume din this cycle; 0: hold state
//  clr        in   1      synchronous clear of state (and counter)
//  din        in   1      serial data bit
//  z          out  1      Moore match flag; high only while in state PAT_LEN
//  match_cnt  out  CNT_W  saturating count of matches (only with MATCH_COUNT_EN)
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low. reset_n=0 -> state=0, z=0, match_cnt=0, immediately and regardless of clk.
//  - State ps in 0..PAT_LEN. The state equals the number of pattern prefix bits currently matched. Width is $clog2(PAT_LEN+1).
//  - Next state on a clk edge with en=1, clr=0 (bit b=din):
//    * ps<PAT_LEN: if b==PATTERN[PAT_LEN-1-ps], ps+1. Otherwise ns is the longest k<=ps such that
//      the last k bits seen (including b) equal the first k pattern bits (KMP fallback).
//    * ps==PAT_LEN, OVERLAP=1: ns is the same fallback rule applied from the longest proper border of PATTERN.
//    * ps==PAT_LEN, OVERLAP=0: ns = (b==PATTERN[PAT_LEN-1]) ? 1 : 0.
//  - en=0: ps holds. z holds, because it is a function of ps only.
//  - clr=1 (with reset_n=1): ps<=0 and match_cnt<=0 on the next edge. clr has priority over en.
//  - z is registered-state decoded (pure Moore). Latency: z rises in the cycle after the edge that samples the
//    last pattern bit, and stays high for exactly one en-cycle unless the next bit completes another match.
//  - Transition table is computed at elaboration by package function; no runtime pattern load.
//  - Illegal ps values (>PAT_LEN) -> ns=0, z=0.
//  - Reset asserted mid-sequence discards partial match; first post-reset bit is treated as a fresh start.
// CONFIGURATION
//  - MATCH_COUNT_EN defined: match_cnt port present. It increments by 1 on each edge where ns==PAT_LEN
//    (en=1, clr=0) and saturates at 2**CNT_W-1, with no wrap. clr and reset zero it.
//  - MATCH_COUNT_EN undefined: match_cnt port and counter logic absent; CNT_W ignored.
// STRUCTURE
//  - Package moore_seq_pkg: function state_w(len); function next_state(ps, b, pattern, len, overlap)
//    (KMP transition); localparam ST_IDLE=0.
//  - Sub-module sat_counter #(W) (clk, reset_n, clr, inc, q), instantiated only under MATCH_COUNT_EN.
//  - Top: state register, next-state via package function, z decode.
// TESTING
//  1. reset_n=0 at arbitrary time mid-stream -> z=0, ps=0, match_cnt=0 asynchronously; release, feed 1100 -> z=1 after 4th edge.
//  2. Default PATTERN=1100, din=1,1,1,0,0 (en=1) -> no false hit at bit 3; z=1 for one cycle after 5th edge.
//  3. PATTERN=4'b1010, OVERLAP=1, din=101010 -> z pulses after edges 4 and 6; OVERLAP=0 same stream -> only after edge 4.
//  4. din=1,1,(en=0 for 5 cycles, din toggling),0,0 -> state frozen during en=0; z=1 after last enabled bit.
//  5. clr=1 with ps=3 -> ps=0 next edge, z stays 0; en=1 and clr=1 together -> clr wins.
//  6. MATCH_COUNT_EN, CNT_W=2, 5 matches of 1100 -> match_cnt=3 (saturated); clr -> 0.

Source files
------------

// File: rtl/moore_seq_pkg.sv
// Shared types and elaboration-time helpers for the parametrised Moore pattern detector.
// next_state() implements the KMP-style prefix fallback used to build the transition table.
package moore_seq_pkg;

    localparam int unsigned ST_IDLE = 0;
    localparam int unsigned MAX_LEN = 16;

    function automatic int unsigned state_w(input int unsigned len);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 6; i++) begin
            if ((32'd1 << w) < len + 1) w = w + 1;
        end
        return w;
    endfunction

    // Pattern bit i counted from the first bit received (MSB of the pattern).
    function automatic logic pat_bit(input logic [15:0] pattern, input int unsigned len,
                                     input int unsigned i);
        logic [15:0] t;
        t = pattern >> (len - 1 - i);
        return t[0];
    endfunction

    function automatic int unsigned next_state(input int unsigned ps, input logic b,
                                               input logic [15:0] pattern, input int unsigned len,
                                               input bit overlap);
        logic        h [32];
        int unsigned m;
        int unsigned best;
        bit          ok;
        if (ps > len) return ST_IDLE;
        if (ps == len && !overlap) return (b == pat_bit(pattern, len, 0)) ? 1 : 0;
        for (int unsigned i = 0; i < 32; i++) h[5'(i)] = 1'b0;
        // History is the matched prefix followed by the new bit; find its longest
        // suffix that is also a pattern prefix, capped at len (proper border after a match).
        m = ps + 1;
        for (int unsigned i = 0; i < 17; i++) begin
            if (i < ps)       h[5'(i)] = pat_bit(pattern, len, i);
            else if (i == ps) h[5'(i)] = b;
        end
        best = 0;
        for (int unsigned k = 1; k <= MAX_LEN; k++) begin
            if (k <= m && k <= len) begin
                ok = 1'b1;
                for (int unsigned j = 0; j < MAX_LEN; j++) begin
                    if (j < k && h[5'(m - k + j)] != pat_bit(pattern, len, j)) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign q = cnt_q;

endmodule

// File: rtl/moore_seq_detector.sv
// Parametrised Moore serial pattern detector; state = number of pattern prefix bits matched.
// Define MATCH_COUNT_EN to add the saturating match_cnt output.
module moore_seq_detector
    import moore_seq_pkg::*;
#(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1100,
    parameter bit                 OVERLAP = 1'b1,
    parameter int unsigned        CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic             din,
    output logic             z
`ifdef MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam int unsigned SW     = state_w(PAT_LEN);
    localparam int unsigned NUM_ST = 1 << SW;

    typedef logic [SW-1:0] state_t;

    localparam state_t ST_RESET = state_t'(ST_IDLE);
    localparam state_t ST_MATCH = state_t'(PAT_LEN);

    if (PAT_LEN < 2 || PAT_LEN > MAX_LEN) begin : g_bad_len
        $error("moore_seq_detector: PAT_LEN must be 2..16");
    end
    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("moore_seq_detector: CNT_W must be nonzero");
    end

    // Full table over every encodable state; codes above PAT_LEN map to idle.
    state_t ns_tbl [NUM_ST][2];

    for (genvar s = 0; s < NUM_ST; s++) begin : g_st
        for (genvar bv = 0; bv < 2; bv++) begin : g_b
            localparam state_t NS = state_t'(next_state(s, 1'(bv), 16'(PATTERN), PAT_LEN, OVERLAP));
            assign ns_tbl[s][bv] = NS;
        end
    end

    state_t ps_q;
    state_t ps_d;
    logic   z_q;
    logic   z_d;

    // z is registered from the next state, so it always equals the decode of ps_q.
    always_comb begin
        ps_d = ps_q;
        z_d  = z_q;
        if (clr) begin
            ps_d = ST_RESET;
            z_d  = 1'b0;
        end else if (en) begin
            ps_d = ns_tbl[ps_q][din];
            z_d  = (ps_d == ST_MATCH);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps_q <= ST_RESET;
            z_q  <= 1'b0;
        end else begin
            ps_q <= ps_d;
            z_q  <= z_d;
        end
    end

    assign z = z_q;

`ifdef MATCH_COUNT_EN
    logic cnt_inc;

    assign cnt_inc = en && !clr && (ps_d == ST_MATCH);

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (clr),
        .inc    (cnt_inc),
        .q      (match_cnt)
    );
`endif

endmodule
